msg_tx: RTL and testbench

MSG_TX -- requirements
Module: msg_tx

---
 rtl/msg_tx.sv | 123 ++++++++++++
 tb/tb_msg_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/msg_tx.sv
// msg_tx: UART 8N1 transmitter for fixed-format HC-05 status messages.
// Ports: clk, rst_n (async active-low), send/msg_sel/unit/block request inputs,
// tx serial line (idle high), busy, done (1-cycle pulse), msg_count (wraps 7->0).
// Macro TX_CRLF_EN appends CR LF after the final '#'.
module msg_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [1:0] msg_sel,
  input  logic [1:0] unit,
  input  logic [1:0] block,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] msg_count
);
`ifdef TX_CRLF_EN
  localparam logic [3:0] EXTRA = 4'd2;
`else
  localparam logic [3:0] EXTRA = 4'd0;
`endif
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT_CHAR} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [3:0] chr_q;
  logic [1:0] sel_q, unit_q, blk_q;
  logic tx_q, busy_q, done_q;
  logic [2:0] count_q;
  logic [3:0] pos, last_chr;
  logic [7:0] ch, unit_ch;
  logic bit_end;
  assign bit_end = cnt_q == LAST;
  assign last_chr = (sel_q == 2'd0 ? 4'd7 : 4'd10) + EXTRA;
  assign unit_ch = unit_q == 2'd0 ? "E" : unit_q == 2'd1 ? "C" : unit_q == 2'd2 ? "R" : "S";
  // FIM lacks the "Bn-" field, so its tail shares table positions with PBM/BDM.
  assign pos = (sel_q == 2'd0 && chr_q >= 4'd7) ? chr_q + 4'd3 : chr_q;
  always_comb begin
    ch = 8'h00;
    case (pos)
      4'd0:  ch = sel_q == 2'd0 ? "F" : sel_q == 2'd1 ? "P" : "B";
      4'd1:  ch = sel_q == 2'd0 ? "I" : sel_q == 2'd1 ? "B" : "D";
      4'd2:  ch = "M";
      4'd3:  ch = "-";
      4'd4:  ch = unit_ch;
      4'd5:  ch = "U";
      4'd6:  ch = "-";
      4'd7:  ch = "B";
      4'd8:  ch = 8'h31 + {6'd0, blk_q};
      4'd9:  ch = "-";
      4'd10: ch = "#";
      4'd11: ch = 8'h0D;
      4'd12: ch = 8'h0A;
      default: ch = 8'h00;
    endcase
  end
  // NEXT_CHAR is resolved inside the final STOP cycle so stop and next start abut.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      chr_q   <= '0;
      sel_q   <= '0;
      unit_q  <= '0;
      blk_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (send && msg_sel != 2'd3) begin
          sel_q   <= msg_sel;
          unit_q  <= unit;
          blk_q   <= block;
          chr_q   <= '0;
          state_q <= START;
          busy_q  <= 1'b1;
          tx_q    <= 1'b0;
        end
        START: if (bit_end) begin
          state_q <= DATA;
          bit_q   <= '0;
          tx_q    <= ch[0];
        end
        DATA: if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            bit_q <= bit_q + 3'd1;
            tx_q  <= ch[bit_q + 3'd1];
          end
        end
        STOP: if (bit_end) begin
          if (chr_q == last_chr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            count_q <= count_q + 3'd1;
            tx_q    <= 1'b1;
          end else begin
            chr_q   <= chr_q + 4'd1;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign tx = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign msg_count = count_q;
endmodule

// File: tb/tb_msg_tx.sv
// tb_msg_tx: directed checks of msg_tx against a per-cycle line model and a mid-bit UART monitor.
module tb_msg_tx;
  localparam int P = 16;
`ifdef TX_CRLF_EN
  localparam int FIM_CYC = 1600;
`else
  localparam int FIM_CYC = 1280;
`endif
  logic clk = 0, rst_n = 1, send = 0, tx, busy, done;
  logic [1:0] msg_sel = 0, unit = 0, block = 0;
  logic [2:0] msg_count;
  int n_chk = 0, n_fail = 0;
  bit exp_q[$];
  logic m_done = 0;
  logic [2:0] m_count = 0;
  logic [7:0] rxq[$];
  int mon_cnt = 0;
  bit mon_on = 0;
  logic [7:0] mon_b;
  msg_tx #(.CLKS_PER_BIT(P)) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .msg_sel(msg_sel), .unit(unit),
    .block(block), .tx(tx), .busy(busy), .done(done), .msg_count(msg_count)
  );
  always #5 clk = ~clk;
  function automatic string msg_str(input logic [1:0] s, u, b);
    string l = "ECRS";
    string r;
    r = s == 0 ? $sformatf("FIM-%cU-#", l[u]) :
        $sformatf("%s-%cU-B%c-#", s == 1 ? "PBM" : "BDM", l[u], 8'h31 + {6'd0, b});
`ifdef TX_CRLF_EN
    r = {r, "\r\n"};
`endif
    return r;
  endfunction
  function automatic void push_msg(input string m);
    for (int i = 0; i < m.len(); i++) begin
      logic [7:0] c = m[i];
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < P; j++) exp_q.push_back(k == 0 ? 1'b0 : k == 9 ? 1'b1 : c[k-1]);
    end
  endfunction
  // Line model: one queued level per clock of the message being sent.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_done = 0;
      m_count = 0;
    end else begin
      bit acc;
      acc = send && exp_q.size() == 0 && msg_sel != 2'd3;
      m_done = 0;
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_done = 1;
          m_count = m_count + 3'd1;
        end
      end
      if (acc) push_msg(msg_str(msg_sel, unit, block));
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      logic e_tx, e_busy;
      e_busy = exp_q.size() > 0;
      e_tx = e_busy ? exp_q[0] : 1'b1;
      n_chk++;
      if (tx !== e_tx || busy !== e_busy || done !== m_done || msg_count !== m_count) begin
        n_fail++;
        if (n_fail < 30)
          $display("FAIL model t=%0t tx/busy/done/cnt got %b%b%b/%0d want %b%b%b/%0d",
                   $time, tx, busy, done, msg_count, e_tx, e_busy, m_done, m_count);
      end
    end
  end
  // UART receiver sampling each bit at its midpoint.
  always @(negedge clk) begin
    if (!rst_n) mon_on <= 0;
    else if (!mon_on) begin
      if (tx === 1'b0) begin
        mon_on <= 1;
        mon_cnt <= 1;
        if (P / 2 == 0) mon_b <= 0;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt % P == P / 2) begin
        int k;
        k = mon_cnt / P;
        if (k >= 1 && k <= 8) mon_b[k-1] <= tx;
        if (k == 9) begin
          n_chk++;
          if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_bit got %b want 1", tx);
          end
          rxq.push_back(mon_b);
          mon_on <= 0;
        end
      end
    end
  end
  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask
  task automatic chk_rx(input string nm, input string want);
    string got = "";
    foreach (rxq[i]) got = {got, $sformatf("%c", rxq[i])};
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got \"%s\" want \"%s\"", nm, got, want);
    end
  endtask
  task automatic pulse(input logic [1:0] s, u, b);
    @(posedge clk) #2;
    send = 1; msg_sel = s; unit = u; block = b;
    @(posedge clk) #2;
    send = 0;
  endtask
  task automatic wait_done(input string nm, output int bc);
    bc = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s timeout waiting for done", nm);
  endtask
  task automatic do_reset();
    @(posedge clk) #2;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    rxq.delete();
  endtask
  initial begin
    int bc;
    #1 rst_n = 0;
    #2;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_count", msg_count, 0);
    @(posedge clk) #2 rst_n = 1;
    pulse(0, 0, 0);
    wait_done("fim", bc);
    chk("fim_busy_cycles", bc, FIM_CYC);
    chk_rx("fim_text", msg_str(0, 0, 0));
    chk("fim_count", msg_count, 1);
    @(negedge clk);
    chk("fim_done_width", done, 0);
    rxq.delete();
    pulse(1, 3, 2);
    wait_done("pbm", bc);
`ifdef TX_CRLF_EN
    chk_rx("pbm_text", "PBM-SU-B3-#\r\n");
`else
    chk_rx("pbm_text", "PBM-SU-B3-#");
`endif
    chk("pbm_count", msg_count, 2);
    rxq.delete();
    pulse(2, 1, 0);
    repeat (998) @(posedge clk);
    #2 send = 1; msg_sel = 0;
    @(posedge clk) #2 send = 0;
    wait_done("bdm", bc);
    pulse(3, 0, 0);
    repeat (60) @(negedge clk);
    chk("illegal_busy", busy, 0);
    chk_rx("busy_ignore_text", msg_str(2, 1, 0));
    chk("illegal_count", msg_count, 3);
    rxq.delete();
    pulse(0, 2, 0);
    repeat (2 * 10 * P + 5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", msg_count, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    rxq.delete();
    pulse(0, 2, 0);
    wait_done("after_rst", bc);
`ifdef TX_CRLF_EN
    chk_rx("after_rst_text", "FIM-RU-#\r\n");
`else
    chk_rx("after_rst_text", "FIM-RU-#");
`endif
    chk("after_rst_count", msg_count, 1);
    do_reset();
    @(posedge clk) #2;
    send = 1; msg_sel = 0; unit = 1;
    for (int d = 0; d < 8; d++) begin
      wait_done("b2b", bc);
      @(negedge clk);
      if (d < 7) begin
        chk("b2b_restart_busy", busy, 1);
        chk("b2b_restart_tx", tx, 0);
      end else chk("b2b_final_busy", busy, 0);
      if (d == 6) send = 0;
    end
    chk("b2b_wrap_count", msg_count, 0);
    begin
      string w = "";
      for (int d = 0; d < 8; d++) w = {w, msg_str(0, 1, 0)};
      chk_rx("b2b_text", w);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
